// File: rtl/hwag_pkg.sv
// Shared types and register map for the hwag configuration loader.
// Readback pass is enabled by defining HWAG_CFG_VERIFY_EN.
package hwag_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_FETCH,
        WR_REQ,
        RD_FETCH,
        RD_REQ,
        CR_FETCH,
        CR_REQ,
        DONE,
        ERR
    } hwag_cfg_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISMATCH = 2'd1,
        ERR_TIMEOUT  = 2'd2
    } hwag_err_t;

    localparam int unsigned HWATHNB     = 4;
    localparam int unsigned HWASTWD     = 5;
    localparam int unsigned HWAATOPL    = 6;
    localparam int unsigned HWACR0      = 63;
    localparam int unsigned HWATHVL     = 70;
    localparam int unsigned HWAIGNCHRGL = 127;
    localparam int unsigned HWAIGNANGL  = 129;

endpackage

// File: rtl/hwag_bus_tmo.sv
// Register-bus acknowledge watchdog: expired flags the TMO_CYC-th waiting cycle.
module hwag_bus_tmo #(
    parameter int unsigned TMO_CYC = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic ack,
    output logic expired
);

    localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);
    localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_CYC - 1);

    logic [TMO_W-1:0] count;

    // count equals the number of cycles already waited, so expiry lands on the last allowed one
    always_ff @(posedge clk) begin
        if (rst || clear || ack) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + TMO_W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/hwag_cfg_loader.sv
// Boot-time loader copying a ROM image into the hwag register bank, HWACR0 last.
// Optional readback/compare pass compiled in with HWAG_CFG_VERIFY_EN.
module hwag_cfg_loader
    import hwag_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NREG    = 131,
    parameter int unsigned CR_ADDR = HWACR0,
    parameter int unsigned TMO_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic [ADDR_W-1:0] err_addr,
    output logic [ADDR_W-1:0] tbl_addr,
    input  logic [DATA_W-1:0] tbl_data,
    output logic              reg_req,
    output logic              reg_we,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic              reg_ack
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_CR  = CNT_W'(CR_ADDR);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(NREG);

    hwag_cfg_state_t   state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] img;
    logic              fresh;
    logic              in_req;
    logic              expired;

    assign in_req   = (state == WR_REQ) || (state == RD_REQ) || (state == CR_REQ);
    assign tbl_addr = cnt[ADDR_W-1:0];

    // ROM word arrives in the first request cycle; it is passed through then and held afterwards
    assign img       = fresh ? tbl_data : word;
    assign reg_wdata = img;

`ifndef HWAG_CFG_VERIFY_EN
    logic unused_rdata;
    assign unused_rdata = ^reg_rdata;
`endif

    hwag_bus_tmo #(
        .TMO_CYC(TMO_CYC)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clear  (!in_req),
        .ack    (reg_ack),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            word     <= '0;
            fresh    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= ERR_NONE;
            err_addr <= '0;
            reg_req  <= 1'b0;
            reg_we   <= 1'b0;
            reg_addr <= '0;
        end else begin
            fresh <= 1'b0;
            if (fresh) begin
                word <= tbl_data;
            end
            // ack has priority over a timeout expiring in the same cycle
            if (in_req && !reg_ack && expired) begin
                reg_req  <= 1'b0;
                err      <= ERR_TIMEOUT;
                err_addr <= reg_addr;
                state    <= ERR;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            done     <= 1'b0;
                            err      <= ERR_NONE;
                            err_addr <= '0;
                            cnt      <= '0;
                            busy     <= 1'b1;
                            state    <= WR_FETCH;
                        end
                    end
                    WR_FETCH: begin
                        if (cnt == CNT_CR) begin
                            cnt <= cnt + CNT_ONE;
                        end else if (cnt == CNT_END) begin
`ifdef HWAG_CFG_VERIFY_EN
                            cnt   <= '0;
                            state <= RD_FETCH;
`else
                            cnt   <= CNT_CR;
                            state <= CR_FETCH;
`endif
                        end else begin
                            reg_req  <= 1'b1;
                            reg_we   <= 1'b1;
                            reg_addr <= cnt[ADDR_W-1:0];
                            fresh    <= 1'b1;
                            state    <= WR_REQ;
                        end
                    end
                    WR_REQ: begin
                        if (reg_ack) begin
                            reg_req <= 1'b0;
                            cnt     <= cnt + CNT_ONE;
                            state   <= WR_FETCH;
                        end
                    end
`ifdef HWAG_CFG_VERIFY_EN
                    RD_FETCH: begin
                        if (cnt == CNT_CR) begin
                            cnt <= cnt + CNT_ONE;
                        end else if (cnt == CNT_END) begin
                            cnt   <= CNT_CR;
                            state <= CR_FETCH;
                        end else begin
                            reg_req  <= 1'b1;
                            reg_we   <= 1'b0;
                            reg_addr <= cnt[ADDR_W-1:0];
                            fresh    <= 1'b1;
                            state    <= RD_REQ;
                        end
                    end
                    RD_REQ: begin
                        if (reg_ack) begin
                            reg_req <= 1'b0;
                            if (reg_rdata != img) begin
                                err      <= ERR_MISMATCH;
                                err_addr <= cnt[ADDR_W-1:0];
                                state    <= ERR;
                            end else begin
                                cnt   <= cnt + CNT_ONE;
                                state <= RD_FETCH;
                            end
                        end
                    end
`endif
                    CR_FETCH: begin
                        reg_req  <= 1'b1;
                        reg_we   <= 1'b1;
                        reg_addr <= CNT_CR[ADDR_W-1:0];
                        fresh    <= 1'b1;
                        state    <= CR_REQ;
                    end
                    CR_REQ: begin
                        if (reg_ack) begin
                            reg_req <= 1'b0;
                            state   <= DONE;
                        end
                    end
                    DONE: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    ERR: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hwag_cfg_loader.sv
// Scoreboard bench for hwag_cfg_loader: reference op list vs observed bus transfers.
module tb_hwag_cfg_loader;

    localparam int NREG = 131;
    localparam int CR   = 63;
    localparam int TMO  = 15;
`ifdef HWAG_CFG_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic        clk, rst, start;
    logic        busy, done;
    logic [1:0]  err;
    logic [7:0]  err_addr, tbl_addr, reg_addr;
    logic [15:0] tbl_data, reg_wdata, reg_rdata;
    logic        reg_req, reg_we, reg_ack;

    hwag_cfg_loader #(
        .ADDR_W (8),
        .DATA_W (16),
        .NREG   (NREG),
        .CR_ADDR(CR),
        .TMO_CYC(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_addr (err_addr),
        .tbl_addr (tbl_addr),
        .tbl_data (tbl_data),
        .reg_req  (reg_req),
        .reg_we   (reg_we),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata),
        .reg_ack  (reg_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit we;
        int addr;
        int data;
    } op_t;

    op_t         exp_q[$];
    op_t         got;
    logic [15:0] rom  [0:255];
    logic [15:0] regs [0:255];
    int checks = 0, errors = 0;
    int exp_done, exp_err, exp_eaddr;
    int bad_addr = -1, hang_addr = -1, slow_addr = -1;
    bit stray_mode = 1'b0;
    int last_age = 0, done_rises = 0, cr_writes = 0;
    bit done_prev = 1'b0;

    always @(posedge clk) tbl_data <= rom[tbl_addr];

    // Register slave: random ack latency, optional corrupt read, hang or late ack at chosen addresses
    initial begin : slave
        int age, target;
        bit acked;
        age = 0; target = 2; acked = 1'b0;
        reg_ack = 1'b0; reg_rdata = '0;
        forever begin
            @(posedge clk); #1;
            reg_ack = 1'b0;
            if (reg_req && !acked && !rst) begin
                age++;
                if (age == 1)
                    target = (int'(reg_addr) == slow_addr) ? TMO : int'($urandom_range(2, 6));
                if (age >= target && int'(reg_addr) != hang_addr) begin
                    reg_ack = 1'b1;
                    acked   = 1'b1;
                    if (reg_we) regs[reg_addr] = reg_wdata;
                    else if (int'(reg_addr) == bad_addr) reg_rdata = regs[reg_addr] + 16'd1;
                    else reg_rdata = regs[reg_addr];
                end
            end else if (!reg_req) begin
                if (age != 0) last_age = age;
                age = 0;
                acked = 1'b0;
                reg_ack = stray_mode;
            end
        end
    end

    // Monitor: every acknowledged transfer is popped against the reference op list
    always @(negedge clk) begin
        if (done && !done_prev) done_rises++;
        done_prev = done;
        if (!rst && reg_req && reg_ack) begin
            if (reg_we && int'(reg_addr) == CR) cr_writes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL bus_op: got we=%0b addr=%0d wdata=%0d, required no further transfer",
                         reg_we, reg_addr, reg_wdata);
            end else begin
                got = exp_q.pop_front();
                if (reg_we != got.we || int'(reg_addr) != got.addr ||
                    (got.we && int'(reg_wdata) != got.data)) begin
                    errors++;
                    $display("FAIL bus_op: got we=%0b addr=%0d wdata=%0d, required we=%0b addr=%0d wdata=%0d",
                             reg_we, reg_addr, reg_wdata, got.we, got.addr, got.data);
                end
            end
        end
    end

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    task automatic push_op(input bit we, input int a);
        op_t o;
        o.we = we; o.addr = a; o.data = int'(rom[a]);
        exp_q.push_back(o);
    endtask

    // Reference: ordered list of transfers and final status derived from the loader's rules
    task automatic build_expected(input int bad, input int hang);
        exp_q.delete();
        exp_done = 1; exp_err = 0; exp_eaddr = 0;
        for (int a = 0; a < NREG; a++) begin
            if (a == CR) continue;
            if (a == hang) begin exp_done = 0; exp_err = 2; exp_eaddr = a; return; end
            push_op(1'b1, a);
        end
        if (VERIFY) begin
            for (int a = 0; a < NREG; a++) begin
                if (a == CR) continue;
                if (a == hang) begin exp_done = 0; exp_err = 2; exp_eaddr = a; return; end
                push_op(1'b0, a);
                if (a == bad) begin exp_done = 0; exp_err = 1; exp_eaddr = a; return; end
            end
        end
        if (hang == CR) begin exp_done = 0; exp_err = 2; exp_eaddr = CR; return; end
        push_op(1'b1, CR);
    endtask

    task automatic load_spec_table();
        for (int i = 0; i < 256; i++) rom[i] = '0;
        rom[4] = 16'd57;  rom[5] = 16'd4;     rom[6] = 16'd3839; rom[63] = 16'd7;
        rom[70] = 16'd2;  rom[127] = 16'd1024; rom[129] = 16'd3830;
    endtask

    task automatic load_random_table();
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom_range(0, 65535));
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_load(input string name, input int bad, input int hang, input int poke);
        bit finished;
        bad_addr = bad; hang_addr = hang;
        build_expected(bad, hang);
        pulse_start();
        finished = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (!busy) begin finished = 1'b1; break; end
            @(posedge clk); #1;
            start = (i == poke);
        end
        start = 1'b0;
        check({name, "_finished"}, int'(finished), 1);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_done"}, int'(done), exp_done);
        check({name, "_err"}, int'(err), exp_err);
        check({name, "_err_addr"}, int'(err_addr), exp_eaddr);
        check({name, "_ops_left"}, exp_q.size(), 0);
        bad_addr = -1; hang_addr = -1;
    endtask

    initial begin : main
        int rises0, cr0;
        bit found;
        rst = 1'b1; start = 1'b0;
        load_spec_table();
        repeat (3) @(posedge clk); #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_err_addr", int'(err_addr), 0);
        check("rst_reg_req", int'(reg_req), 0);
        check("rst_tbl_addr", int'(tbl_addr), 0);
        rst = 1'b0;

        run_load("nominal", -1, -1, -1);

        load_random_table();
        stray_mode = 1'b1;
        run_load("stray_ack", -1, -1, -1);
        stray_mode = 1'b0;

        slow_addr = 100;
        run_load("ack_at_expiry", -1, -1, -1);
        slow_addr = -1;

        load_spec_table();
        run_load("mismatch", 4, -1, -1);

        load_random_table();
        run_load("mismatch_rand", int'($urandom_range(0, 62)), -1, -1);

        load_spec_table();
        run_load("timeout", -1, 70, -1);
        check("timeout_req_cycles", last_age, TMO);

        load_random_table();
        build_expected(-1, -1);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #1;
            if (reg_req && reg_we && reg_addr == 8'd50) begin found = 1'b1; break; end
        end
        check("rst_mid_reached_50", int'(found), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_reg_req", int'(reg_req), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_done", int'(done), 0);
        exp_q.delete();
        repeat (5) @(posedge clk); #1;
        check("rst_mid_no_resume", int'(busy || reg_req), 0);
        run_load("restart", -1, -1, -1);

        rises0 = done_rises; cr0 = cr_writes;
        run_load("start_busy", -1, -1, int'($urandom_range(5, 400)));
        check("start_busy_done_rises", done_rises - rises0, 1);
        check("start_busy_cr_writes", cr_writes - cr0, 1);

        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("rst_start_busy", int'(busy), 0);
        check("rst_start_reg_req", int'(reg_req), 0);

        stray_mode = 1'b1;
        repeat (6) @(posedge clk); #1;
        stray_mode = 1'b0;
        check("idle_ack_busy", int'(busy), 0);
        check("idle_ack_done", int'(done), 0);
        check("idle_ack_err", int'(err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hwag_cfg_loader.md
Name: hwag_cfg_loader

Overview:
- Boot-time configuration sequencer for the hwag angle-generator register bank. Runs once per start request.
- Copies a register image from a synchronous table ROM into hwag registers 0..NREG-1 over a req/ack register bus.
- Optionally reads every written register back and compares it with the image.
- Writes the control register (HWACR0) last, so the capture/ignition logic is enabled only after the rest of the bank is valid.

Parameters:
- ADDR_W, 8, register/table address width
- DATA_W, 16, register data width
- NREG, 131, number of register addresses covered (0..NREG-1)
- CR_ADDR, 63, address of HWACR0; skipped in the bulk pass and written last
- TMO_CYC, 15, maximum cycles to wait for reg_ack before declaring a timeout

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle start pulse; ignored while busy
- busy  out  1  sequence in progress
- done  out  1  sticky; sequence completed without error
- err  out  2  sticky error code: 0 none, 1 readback mismatch, 2 ack timeout
- err_addr  out  ADDR_W  register address at which the error occurred
- tbl_addr  out  ADDR_W  table ROM address
- tbl_data  in  DATA_W  table ROM data, valid 1 cycle after tbl_addr
- reg_req  out  1  register bus request
- reg_we  out  1  1 = write, 0 = read; valid while reg_req is high
- reg_addr  out  ADDR_W  register address
- reg_wdata  out  DATA_W  write data
- reg_rdata  in  DATA_W  read data, valid in the reg_ack cycle
- reg_ack  in  1  single-cycle acknowledge, asserted at least 1 cycle after reg_req rises

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0, FSM in IDLE, address counter 0.
  - rst asserted mid-sequence drops reg_req in the next cycle, with no partial transfer.
  - The sequence does not resume after reset.
- FSM states: IDLE, WR_FETCH, WR_REQ, RD_FETCH, RD_REQ, CR_FETCH, CR_REQ, DONE, ERR.
- IDLE:
  - On start: clear done, err and err_addr; set cnt=0; set busy=1; go to WR_FETCH.
- WR_FETCH:
  - If cnt==CR_ADDR, increment cnt and stay in WR_FETCH.
  - If cnt==NREG, go to RD_FETCH with cnt=0.
  - Otherwise drive tbl_addr=cnt for 1 cycle, then go to WR_REQ.
- WR_REQ:
  - reg_req=1, reg_we=1, reg_addr=cnt, reg_wdata=tbl_data (captured from the fetch).
  - All bus signals are held stable until reg_ack.
  - On reg_ack: drop reg_req in the next cycle, increment cnt, go to WR_FETCH.
- RD_FETCH / RD_REQ:
  - Same address walk as WR_FETCH / WR_REQ, including the CR_ADDR skip, with reg_we=0.
  - The table word is held in a register for the compare.
  - On reg_ack, compare reg_rdata with the table word.
  - Mismatch: err=1, err_addr=cnt, go to ERR.
  - Match: increment cnt; at cnt==NREG go to CR_FETCH.
- CR_FETCH / CR_REQ:
  - Fetch tbl[CR_ADDR] and write it to CR_ADDR.
  - On reg_ack go to DONE.
- DONE:
  - done=1, busy=0, return to IDLE.
  - done stays high until the next start or rst.
- Timeout:
  - A counter is cleared on entry to any *_REQ state.
  - If it reaches TMO_CYC without reg_ack: err=2, err_addr=reg_addr, drop reg_req, go to ERR.
- ERR:
  - busy=0; the control register is never written.
  - Return to IDLE; err is held until the next start or rst.
- Boundary conditions:
  - reg_ack outside a *_REQ state is ignored.
  - start while busy is ignored.
  - start in the same cycle as rst: rst wins.
  - reg_ack in the same cycle the timeout count expires: ack wins.
- Widths: cnt is ADDR_W+1 bits so NREG up to 2^ADDR_W is reachable without wrap. The timeout counter is $clog2(TMO_CYC+1) bits.

Optional Feature:
- Macro: HWAG_CFG_VERIFY_EN
- Defined: the readback pass (RD_FETCH / RD_REQ) is compiled in, and err code 1 is reachable.
- Undefined: WR_FETCH at cnt==NREG goes directly to CR_FETCH. No read cycles are issued (reg_we is never 0 while reg_req is high), and err is only ever 0 or 2.

Decomposition:
- Shared package hwag_pkg:
  - FSM state enum (hwag_cfg_state_t).
  - Error code enum: ERR_NONE=0, ERR_MISMATCH=1, ERR_TIMEOUT=2.
  - Register address constants: HWATHNB=4, HWASTWD=5, HWAATOPL=6, HWACR0=63, HWATHVL=70, HWAIGNCHRGL=127, HWAIGNANGL=129.
- One natural sub-module, hwag_bus_tmo: the req/ack timeout counter with inputs clear and ack, output expired.

Test Plan:
- Nominal load, verify on:
  - Stimulus: table with [4]=57, [5]=4, [6]=3839, [63]=7, [70]=2, [127]=1024, [129]=3830, all others 0; model slave acks after 2 cycles.
  - Response: 130 bulk writes, then 130 reads, then one write of 7 to address 63, which is the last reg_req with reg_we=1. done=1, err=0.
- Verify off (macro undefined):
  - Same stimulus.
  - Response: 131 writes, zero reads, address 63 written last, done=1.
- Readback mismatch:
  - Slave returns 58 on a read of address 4.
  - Response: err=1, err_addr=4, done=0, address 63 never written.
- Ack timeout:
  - Slave never acks address 70.
  - Response: reg_req drops 15 cycles after rising, err=2, err_addr=70, busy=0.
- Reset mid-write:
  - rst pulsed while address 50 is being written.
  - Response: next cycle reg_req=0, busy=0, done=0.
  - A subsequent start restarts from address 0.
- Start while busy:
  - A second start pulse mid-sequence.
  - Response: ignored; exactly one address-63 write and one done assertion.
